// File: rtl/devolver_cambio.sv
// Change-return controller: pays out a requested amount using 5-unit coins first,
// then 1-unit coins, handshaking each coin with the ejector and tracking inventory.
module devolver_cambio #(
  parameter int unsigned STOCK5_INIT = 10,
  parameter int unsigned STOCK1_INIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] monto,
  input  logic       refill,
  input  logic       coin_ack,
  output logic       coin_valid,
  output logic       coin_type,
  output logic [5:0] restante,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] stock5,
  output logic [3:0] stock1
);

  localparam logic [3:0] C_STOCK5_INIT = 4'(STOCK5_INIT);
  localparam logic [3:0] C_STOCK1_INIT = 4'(STOCK1_INIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_coin_type;
  logic [5:0] r_restante;
  logic [3:0] r_stock5;
  logic [3:0] r_stock1;

  logic       w_can5;
  logic       w_can1;
  logic       w_ack;

  // A 5-unit coin is only chosen when it cannot overshoot and one is in stock.
  assign w_can5 = (r_restante >= 6'd5) && (r_stock5 != 4'd0);
  assign w_can1 = (r_restante != 6'd0) && (r_stock1 != 4'd0);
  assign w_ack  = (r_state == S_ISSUE) && coin_ack;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_SELECT;
        end
      end
      S_SELECT: begin
        if (r_restante == 6'd0) begin
          w_state_next = S_DONE;
        end else if (w_can5 || w_can1) begin
          w_state_next = S_ISSUE;
        end else begin
          w_state_next = S_ERROR;
        end
      end
      S_ISSUE: begin
        if (coin_ack) begin
          w_state_next = S_SELECT;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      S_ERROR: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: amount, selected coin and inventory
  always_ff @(posedge clk) begin
    if (rst) begin
      r_coin_type <= 1'b0;
      r_restante  <= 6'd0;
      r_stock5    <= C_STOCK5_INIT;
      r_stock1    <= C_STOCK1_INIT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_restante <= monto;
          end else if (refill) begin
            r_stock5 <= C_STOCK5_INIT;
            r_stock1 <= C_STOCK1_INIT;
          end
        end
        S_SELECT: begin
          // Coin type is latched here so it stays stable for the whole handshake.
          if (r_restante != 6'd0) begin
            if (w_can5) begin
              r_coin_type <= 1'b1;
            end else if (w_can1) begin
              r_coin_type <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          if (w_ack) begin
            if (r_coin_type) begin
              r_restante <= r_restante - 6'd5;
              r_stock5   <= r_stock5 - 4'd1;
            end else begin
              r_restante <= r_restante - 6'd1;
              r_stock1   <= r_stock1 - 4'd1;
            end
          end
        end
        S_DONE: begin
          r_restante <= 6'd0;
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode directly from registered state, so they change only on clock edges.
  always_comb begin
    coin_valid = (r_state == S_ISSUE);
    coin_type  = r_coin_type;
    restante   = r_restante;
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
    error      = (r_state == S_ERROR);
    stock5     = r_stock5;
    stock1     = r_stock1;
  end

endmodule

// File: tb/tb_devolver_cambio.sv
// Bench for devolver_cambio: three parameterisations share stimulus; a vector table
// drives complete payouts and directed sequences cover latency, stalls, reset and refill.
module tb_devolver_cambio;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] monto;
  logic       refill;
  logic       coin_ack;

  logic       cv   [3];
  logic       ct   [3];
  logic [5:0] rest [3];
  logic       bsy  [3];
  logic       dn   [3];
  logic       er   [3];
  logic [3:0] s5   [3];
  logic [3:0] s1   [3];

  int n_applied = 0;
  int n_mis     = 0;

  always #5 clk = ~clk;

  // inst 0: defaults, inst 1: no 5-unit coins, inst 2: no 5s and only two 1s
  devolver_cambio #(.STOCK5_INIT(10), .STOCK1_INIT(15)) u_a (
    .clk(clk), .rst(rst), .start(start), .monto(monto), .refill(refill), .coin_ack(coin_ack),
    .coin_valid(cv[0]), .coin_type(ct[0]), .restante(rest[0]), .busy(bsy[0]),
    .done(dn[0]), .error(er[0]), .stock5(s5[0]), .stock1(s1[0]));

  devolver_cambio #(.STOCK5_INIT(0), .STOCK1_INIT(15)) u_b (
    .clk(clk), .rst(rst), .start(start), .monto(monto), .refill(refill), .coin_ack(coin_ack),
    .coin_valid(cv[1]), .coin_type(ct[1]), .restante(rest[1]), .busy(bsy[1]),
    .done(dn[1]), .error(er[1]), .stock5(s5[1]), .stock1(s1[1]));

  devolver_cambio #(.STOCK5_INIT(0), .STOCK1_INIT(2)) u_c (
    .clk(clk), .rst(rst), .start(start), .monto(monto), .refill(refill), .coin_ack(coin_ack),
    .coin_valid(cv[2]), .coin_type(ct[2]), .restante(rest[2]), .busy(bsy[2]),
    .done(dn[2]), .error(er[2]), .stock5(s5[2]), .stock1(s1[2]));

  typedef struct {
    int          inst;
    logic [5:0]  monto;
    int          n_coins;
    logic [63:0] bits;
    logic        is_err;
    logic [5:0]  rest;
    logic [3:0]  s5;
    logic [3:0]  s1;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check_idle(input int k, input logic [3:0] e5, input logic [3:0] e1);
    check("idle_valid", 64'(cv[k]), 64'd0);
    check("idle_type", 64'(ct[k]), 64'd0);
    check("idle_rest", 64'(rest[k]), 64'd0);
    check("idle_busy", 64'(bsy[k]), 64'd0);
    check("idle_done", 64'(dn[k]), 64'd0);
    check("idle_err", 64'(er[k]), 64'd0);
    check("idle_s5", 64'(s5[k]), 64'(e5));
    check("idle_s1", 64'(s1[k]), 64'(e1));
  endtask

  // Runs one full request with ack held high; returns coins seen and the terminal pulse.
  task automatic run_req(input int k, input logic [5:0] m, output int n, output logic [63:0] bits,
                         output logic is_err, output logic [5:0] r_at_end, output logic ok);
    n = 0;
    bits = '0;
    is_err = 1'b0;
    r_at_end = '0;
    ok = 1'b0;
    coin_ack = 1'b1;
    start = 1'b1;
    monto = m;
    step();
    start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (cv[k]) begin
        if (n < 64) bits[n] = ct[k];
        n++;
      end
      if (dn[k] || er[k]) begin
        is_err = er[k];
        r_at_end = rest[k];
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    int n;
    logic [63:0] bits;
    logic is_err;
    logic [5:0] r_end;
    logic ok;

    vecs[0] = '{0, 6'd13, 5,  64'h3,   1'b0, 6'd0, 4'd8, 4'd12};
    vecs[1] = '{0, 6'd0,  0,  64'h0,   1'b0, 6'd0, 4'd10, 4'd15};
    vecs[2] = '{0, 6'd5,  1,  64'h1,   1'b0, 6'd0, 4'd9, 4'd15};
    vecs[3] = '{0, 6'd12, 4,  64'h3,   1'b0, 6'd0, 4'd8, 4'd13};
    vecs[4] = '{0, 6'd63, 23, 64'h3FF, 1'b0, 6'd0, 4'd0, 4'd2};
    vecs[5] = '{1, 6'd7,  7,  64'h0,   1'b0, 6'd0, 4'd0, 4'd8};
    vecs[6] = '{1, 6'd16, 15, 64'h0,   1'b1, 6'd1, 4'd0, 4'd0};
    vecs[7] = '{2, 6'd4,  2,  64'h0,   1'b1, 6'd2, 4'd0, 4'd0};
    vecs[8] = '{2, 6'd2,  2,  64'h0,   1'b0, 6'd0, 4'd0, 4'd0};
    vecs[9] = '{2, 6'd5,  2,  64'h0,   1'b1, 6'd3, 4'd0, 4'd0};

    start = 1'b0;
    monto = '0;
    refill = 1'b0;
    coin_ack = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_idle(0, 4'd10, 4'd15);
    check_idle(1, 4'd0, 4'd15);
    check_idle(2, 4'd0, 4'd2);
    $display("reset: initial idle state checked on all instances");

    for (int v = 0; v < 10; v++) begin
      do_reset();
      run_req(vecs[v].inst, vecs[v].monto, n, bits, is_err, r_end, ok);
      check("terminated", 64'(ok), 64'd1);
      check("coin_count", 64'(n), 64'(vecs[v].n_coins));
      check("coin_types", bits, vecs[v].bits);
      check("is_error", 64'(is_err), 64'(vecs[v].is_err));
      check("rest_at_end", 64'(r_end), 64'(vecs[v].rest));
      check("stock5", 64'(s5[vecs[v].inst]), 64'(vecs[v].s5));
      check("stock1", 64'(s1[vecs[v].inst]), 64'(vecs[v].s1));
      step();
      check("back_idle", 64'(bsy[vecs[v].inst]), 64'd0);
      $display("vec %0d: inst %0d monto %0d -> %0d coins, %s, restante %0d", v, vecs[v].inst,
               vecs[v].monto, n, is_err ? "error" : "done", r_end);
    end

    // monto=0 latency: SELECT then DONE, no coin
    do_reset();
    coin_ack = 1'b1;
    start = 1'b1;
    monto = 6'd0;
    step();
    start = 1'b0;
    check("lat_sel_busy", 64'(bsy[0]), 64'd1);
    check("lat_sel_done", 64'(dn[0]), 64'd0);
    check("lat_sel_valid", 64'(cv[0]), 64'd0);
    step();
    check("lat_done", 64'(dn[0]), 64'd1);
    check("lat_done_rest", 64'(rest[0]), 64'd0);
    step();
    check("lat_done_pulse", 64'(dn[0]), 64'd0);
    check("lat_idle", 64'(bsy[0]), 64'd0);
    $display("seq latency: monto 0 done pulse checked");

    // Stalled handshake with monto=10, plus start during busy
    do_reset();
    coin_ack = 1'b0;
    start = 1'b1;
    monto = 6'd10;
    step();
    start = 1'b0;
    check("stall_sel_valid", 64'(cv[0]), 64'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(cv[0]), 64'd1);
      check("stall_type", 64'(ct[0]), 64'd1);
      check("stall_rest", 64'(rest[0]), 64'd10);
      if (i == 2) begin
        start = 1'b1;
        monto = 6'd3;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    check("stall_rest_after_busy_start", 64'(rest[0]), 64'd10);
    coin_ack = 1'b1;
    step();
    check("stall_acked_rest", 64'(rest[0]), 64'd5);
    check("stall_acked_valid", 64'(cv[0]), 64'd0);
    check("stall_acked_s5", 64'(s5[0]), 64'd9);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (dn[0]) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("stall_done_seen", 64'(ok), 64'd1);
    check("stall_final_s5", 64'(s5[0]), 64'd8);
    $display("seq stall: monto 10 held 5 cycles then completed");

    // Reset mid-handshake of a monto=20 request
    do_reset();
    coin_ack = 1'b1;
    start = 1'b1;
    monto = 6'd20;
    step();
    start = 1'b0;
    step();
    step();
    coin_ack = 1'b0;
    check("rst_first_coin_s5", 64'(s5[0]), 64'd9);
    step();
    check("rst_in_issue", 64'(cv[0]), 64'd1);
    rst = 1'b1;
    coin_ack = 1'b1;
    step();
    rst = 1'b0;
    check_idle(0, 4'd10, 4'd15);
    step();
    check("rst_no_done", 64'(dn[0]), 64'd0);
    check("rst_no_err", 64'(er[0]), 64'd0);
    check("rst_stays_idle", 64'(bsy[0]), 64'd0);
    $display("seq reset: reset during ISSUE returned to idle");

    // Error then refill on the small-stock instance
    do_reset();
    run_req(2, 6'd4, n, bits, is_err, r_end, ok);
    check("refill_pre_err", 64'(is_err), 64'd1);
    step();
    check("refill_pre_s1", 64'(s1[2]), 64'd0);
    refill = 1'b1;
    step();
    refill = 1'b0;
    check("refill_s1", 64'(s1[2]), 64'd2);
    check("refill_s5", 64'(s5[2]), 64'd0);
    $display("seq refill: stock1 restored after error");

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_mis);
    $finish;
  end

endmodule
